// File: rtl/wf_uart_pkg.sv
// Shared types and helpers for the WimpFi host-link UART blocks.
`timescale 1ns/1ps
package wf_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  localparam int OVERSAMPLE = 16;

  // Rounded clk/(baud*16) divider for the oversample tick.
  function automatic int os_div(input longint clk_freq, input longint baud);
    longint den;
    den = baud * longint'(OVERSAMPLE);
    return int'((clk_freq + (den >> 1)) / den);
  endfunction

endpackage

// File: rtl/wf_uart_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, realignable via restart.
`timescale 1ns/1ps
module wf_uart_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !restart && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wf_uart_rx.sv
// 8N1 oversampling UART receiver with majority voting and a 1-entry holding register.
`timescale 1ns/1ps
module wf_uart_rx
  import wf_uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       ferr,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = os_div(longint'(CLK_FREQ), longint'(BAUD_RATE));

  uart_rx_state_t state_q, state_d;
  logic [1:0] sync_q;
  logic       rxd_s, rxd_prev_q, fall;
  logic [3:0] scnt_q, scnt_d, snext;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] shreg_q, shreg_d, data_q;
  logic       s7_q, s8_q, maj, at9, at15;
  logic       valid_q, ferr_q, ovr_q;
  logic       tick, restart, deliver, frame_err;

  assign rxd_s   = sync_q[1];
  assign fall    = rxd_prev_q & ~rxd_s;
  assign restart = (state_q == IDLE) && fall;
  // snext is the index of the tick being consumed this cycle (wraps 15 -> 0)
  assign snext   = scnt_q + 4'd1;
  assign at9     = tick && (snext == 4'd9);
  assign at15    = tick && (snext == 4'd15);
  assign maj     = (s7_q & s8_q) | (s7_q & rxd_s) | (s8_q & rxd_s);

  wf_uart_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bidx_d    = bidx_q;
    shreg_d   = shreg_q;
    deliver   = 1'b0;
    frame_err = 1'b0;
    if (tick) scnt_d = snext;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          scnt_d  = '0;
        end
      end
      START: begin
        if (at9 && maj) state_d = IDLE;
        else if (at15) begin
          state_d = DATA;
          bidx_d  = '0;
        end
      end
      DATA: begin
        if (at9) shreg_d = {maj, shreg_q[7:1]};
        if (at15) begin
          bidx_d = bidx_q + 3'd1;
          if (bidx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed
        if (at9) begin
          if (maj) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      rxd_prev_q <= 1'b1;
      state_q    <= IDLE;
      scnt_q     <= '0;
      bidx_q     <= '0;
      shreg_q    <= '0;
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rxd};
      rxd_prev_q <= rxd_s;
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      bidx_q     <= bidx_d;
      shreg_q    <= shreg_d;
      if (tick && snext == 4'd7) s7_q <= rxd_s;
      if (tick && snext == 4'd8) s8_q <= rxd_s;
      ferr_q <= frame_err;
      ovr_q  <= deliver && valid_q && !rx_ready;
      if (deliver && (!valid_q || rx_ready)) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign ferr     = ferr_q;
  assign overrun  = ovr_q;
  assign busy     = (state_q != IDLE);

endmodule
